// File: rtl/regbank_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : regbank_arbiter                                            |
// | Description : Two-port round-robin arbiter and access sequencer for the  |
// |               four-entry register bank. One transaction at a time walks  |
// |               IDLE -> ACCESS -> CAPTURE -> RESP and ends in a one-cycle  |
// |               completion pulse to the winning requester.                 |
// | Options     : REGARB_ERR_EN - address decode check; illegal accesses     |
// |               are not forwarded to the bank and complete with err = 1.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module regbank_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int A_REGA = 5,
    parameter int A_REGB = 10,
    parameter int A_REGC = 15,
    parameter int A_REGD = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy,
    output logic              bank_wr_en,
    output logic              bank_rd_en,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

`ifdef REGARB_ERR_EN
    localparam logic c_err_en = 1'b1;
`else
    localparam logic c_err_en = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] c_rega = ADDR_W'(A_REGA);
    localparam logic [ADDR_W-1:0] c_regb = ADDR_W'(A_REGB);
    localparam logic [ADDR_W-1:0] c_regc = ADDR_W'(A_REGC);
    localparam logic [ADDR_W-1:0] c_regd = ADDR_W'(A_REGD);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_gnt;
    logic                r_win;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_any_req;
    logic                w_win;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_addr_known;
    logic                w_dec_err;
    logic                w_sel_err;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that did not win last time.
    assign w_any_req   = req0 | req1;
    assign w_win       = (req0 & req1) ? ~r_last_gnt : req1;
    assign w_sel_we    = w_win ? we1    : we0;
    assign w_sel_addr  = w_win ? addr1  : addr0;
    assign w_sel_wdata = w_win ? wdata1 : wdata0;

    // Decode check: unknown address, read of the write-only register or
    // write of the read-only register. Forced to 0 when the check is off.
    assign w_addr_known = (w_sel_addr == c_rega) | (w_sel_addr == c_regb) |
                          (w_sel_addr == c_regc) | (w_sel_addr == c_regd);
    assign w_dec_err    = ~w_addr_known |
                          (~w_sel_we & (w_sel_addr == c_regc)) |
                          ( w_sel_we & (w_sel_addr == c_regd));
    assign w_sel_err    = c_err_en & w_dec_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; every output is a pure function of the
    // current state and latched transaction fields.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        bank_wr_en  = 1'b0;
        bank_rd_en  = 1'b0;
        bank_addr   = '0;
        bank_wdata  = '0;
        done0       = 1'b0;
        done1       = 1'b0;
        rdata0      = '0;
        rdata1      = '0;
        err0        = 1'b0;
        err1        = 1'b0;
        if (r_state != S_IDLE) begin
            bank_addr  = r_addr;
            bank_wdata = r_wdata;
        end
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bank_wr_en  =  r_we & ~r_err;
                bank_rd_en  = ~r_we & ~r_err;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                done0       = ~r_win;
                done1       =  r_win;
                rdata0      = r_win ? '0 : r_rdata;
                rdata1      = r_win ? r_rdata : '0;
                err0        = ~r_win & r_err;
                err1        =  r_win & r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction latch on grant, arbitration history, and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last_gnt <= w_win;
                        r_win      <= w_win;
                        r_we       <= w_sel_we;
                        r_err      <= w_sel_err;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                    end
                end
                S_CAPTURE: begin
                    r_rdata <= (r_we | r_err) ? '0 : bank_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_regbank_arbiter                                         |
// | Description : Self-checking bench for regbank_arbiter with a behavioural |
// |               register-bank model, a vector table, directed corner       |
// |               sequences and a randomized two-requester phase.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_regbank_arbiter;

`ifdef REGARB_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        bank_wr_en, bank_rd_en;
    logic [31:0] bank_addr, bank_wdata, bank_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    bit m_on     = 0;

    regbank_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .bank_wr_en(bank_wr_en), .bank_rd_en(bank_rd_en),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: regA@5, regB@10, regC@15 write-only, regD@20 fixed 99.
    logic [31:0] bk_a, bk_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            bk_a       <= 32'd0;
            bk_b       <= 32'd0;
            bank_rdata <= 32'd0;
        end else begin
            if (bank_wr_en) begin
                if (bank_addr == 32'd5)  bk_a <= bank_wdata;
                if (bank_addr == 32'd10) bk_b <= bank_wdata;
            end
            if (bank_rd_en) begin
                if (bank_addr == 32'd5)       bank_rdata <= bk_a;
                else if (bank_addr == 32'd10) bank_rdata <= bk_b;
                else if (bank_addr == 32'd20) bank_rdata <= 32'd99;
                else                          bank_rdata <= 32'd0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " ctl"}, {done0, done1, err0, err1, busy, bank_wr_en, bank_rd_en}, 0);
        check({nm, " data"}, rdata0 | rdata1 | bank_addr | bank_wdata, 0);
    endtask

    // Single transaction on one port with latency, data, error and enable checks.
    task automatic do_txn(input string nm, input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [1:0] exp_en);
        int cyc = 0;
        bit got = 0, en_bad = 0, other = 0;
        logic [1:0] en_acc = 2'b00;
        logic [31:0] rd = 0;
        logic e = 0;
        @(posedge clk);
        #1 drive(p, 1, w, a, d);
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) en_acc = {bank_wr_en, bank_rd_en};
            else if (bank_wr_en || bank_rd_en) en_bad = 1;
            if ((p == 0) ? done1 : done0) other = 1;
            if ((p == 0) ? done0 : done1) begin
                got = 1;
                rd  = (p == 0) ? rdata0 : rdata1;
                e   = (p == 0) ? err0 : err1;
            end
        end
        check({nm, " done seen"}, got, 1);
        check({nm, " latency"}, cyc - 1, 3);
        check({nm, " rdata"}, rd, exp_rd);
        check({nm, " err"}, e, exp_err);
        check({nm, " enables"}, {en_bad, other, en_acc}, {2'b00, exp_en});
        @(posedge clk);
        #1 drive(p, 0, 0, 0, 0);
        @(negedge clk);
        check({nm, " done pulse width"}, {done0, done1}, 0);
    endtask

    // Transaction-level reference: serial grants, round-robin on ties,
    // 3-cycle request-to-done, register contents kept as plain variables.
    task automatic model_loop();
        int cnt = 0;
        bit last = 1, win = 0, m_err = 0, m_we = 0;
        bit bz, d0, d1, wr, rd;
        logic [31:0] m_addr = 0, m_wdata = 0, m_rd = 0, mem_a = 0, mem_b = 0;
        while (m_on) begin
            @(negedge clk);
            bz = (cnt != 0); d0 = 0; d1 = 0; wr = 0; rd = 0;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 2) begin
                    wr = m_we && !m_err;
                    rd = !m_we && !m_err;
                    check("rnd bank_addr", bank_addr, m_addr);
                    check("rnd bank_wdata", bank_wdata, m_wdata);
                end
                if (cnt == 0) begin d0 = !win; d1 = win; end
            end else if (req0 || req1) begin
                win     = (req0 && req1) ? !last : req1;
                last    = win;
                m_we    = win ? we1 : we0;
                m_addr  = win ? addr1 : addr0;
                m_wdata = win ? wdata1 : wdata0;
                m_err   = ERR && (!(m_addr == 5 || m_addr == 10 || m_addr == 15 || m_addr == 20)
                                  || (!m_we && m_addr == 15) || (m_we && m_addr == 20));
                if (m_err || m_we) m_rd = 0;
                else m_rd = (m_addr == 5) ? mem_a : (m_addr == 10) ? mem_b :
                            (m_addr == 20) ? 32'd99 : 32'd0;
                if (m_we && !m_err && m_addr == 5)  mem_a = m_wdata;
                if (m_we && !m_err && m_addr == 10) mem_b = m_wdata;
                cnt = 3;
            end
            check("rnd ctl", {busy, done0, done1, bank_wr_en, bank_rd_en}, {bz, d0, d1, wr, rd});
            check("rnd rdata0", rdata0, d0 ? m_rd : 32'd0);
            check("rnd rdata1", rdata1, d1 ? m_rd : 32'd0);
            if (d0 || d1) check("rnd err", d0 ? err0 : err1, m_err);
        end
    endtask

    task automatic port_proc(input int p, input int ntx);
        int alist[6] = '{5, 10, 15, 20, 7, 5};
        int w;
        for (int i = 0; i < ntx; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 drive(p, 1, 1'($urandom_range(0, 1)), alist[$urandom_range(0, 5)], $urandom);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!((p == 0) ? done0 : done1) && w < 60);
            if (w >= 60) check("rnd port timeout", 0, 1);
            @(posedge clk);
            #1 drive(p, 0, 0, 0, 0);
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [1:0]  exp_en;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int gp[4];
        int gc[4];
        int got, cyc, both, nd;

        tbl[0]  = '{0, 1'b0, 32'd20, 32'd0,          32'd99,         1'b0, 2'b01};
        tbl[1]  = '{1, 1'b1, 32'd5,  32'hDEADBEEF,   32'd0,          1'b0, 2'b10};
        tbl[2]  = '{1, 1'b0, 32'd5,  32'd0,          32'hDEADBEEF,   1'b0, 2'b01};
        tbl[3]  = '{0, 1'b1, 32'd10, 32'h12345678,   32'd0,          1'b0, 2'b10};
        tbl[4]  = '{1, 1'b0, 32'd10, 32'd0,          32'h12345678,   1'b0, 2'b01};
        tbl[5]  = '{0, 1'b1, 32'd20, 32'h55,         32'd0,          ERR,  ERR ? 2'b00 : 2'b10};
        tbl[6]  = '{1, 1'b0, 32'd15, 32'd0,          32'd0,          ERR,  ERR ? 2'b00 : 2'b01};
        tbl[7]  = '{0, 1'b0, 32'd7,  32'd0,          32'd0,          ERR,  ERR ? 2'b00 : 2'b01};
        tbl[8]  = '{1, 1'b0, 32'd20, 32'd0,          32'd99,         1'b0, 2'b01};
        tbl[9]  = '{0, 1'b1, 32'd15, 32'hCAFE,       32'd0,          1'b0, 2'b10};
        tbl[10] = '{0, 1'b0, 32'd15, 32'd0,          32'd0,          ERR,  ERR ? 2'b00 : 2'b01};
        tbl[11] = '{1, 1'b1, 32'd5,  32'hA5A5A5A5,   32'd0,          1'b0, 2'b10};
        tbl[12] = '{0, 1'b0, 32'd5,  32'd0,          32'hA5A5A5A5,   1'b0, 2'b01};

        rst = 1'b1;
        do_reset();
        @(negedge clk);
        check_all_zero("reset");

        for (int i = 0; i < 13; i++)
            do_txn($sformatf("vec%0d", i), tbl[i].port, tbl[i].we, tbl[i].addr,
                   tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_en);

        // Both requesters raised together after reset and held: 0,1,0,1.
        do_reset();
        @(posedge clk);
        #1;
        drive(0, 1, 0, 20, 0);
        drive(1, 1, 0, 20, 0);
        got = 0; cyc = 0; both = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done0 && done1) both++;
            if (done0 || done1) begin
                gp[got] = done1 ? 1 : 0;
                gc[got] = cyc;
                got++;
            end
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("rr done count", got, 4);
        check("rr simultaneous dones", both, 0);
        for (int i = 0; i < got; i++) begin
            check($sformatf("rr order %0d", i), gp[i], i % 2);
            check($sformatf("rr cycle %0d", i), gc[i], 4 + 4 * i);
        end
        repeat (6) @(posedge clk);

        // Reset during CAPTURE of a read abandons it without done.
        @(posedge clk);
        #1 drive(0, 1, 0, 20, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check_all_zero("mid reset");
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1) nd++;
        end
        check("mid reset no done", nd, 0);
        do_txn("post reset regB", 1, 1'b0, 32'd10, 32'd0, 32'd0, 1'b0, 2'b01);

        // Randomized traffic on both ports against the reference model.
        do_reset();
        @(posedge clk);
        m_on = 1;
        fork
            begin
                fork
                    port_proc(0, 25);
                    port_proc(1, 25);
                join
                repeat (6) @(posedge clk);
                m_on = 0;
            end
            model_loop();
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
